// File: rtl/wb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// wb_regfile_pkg
// Shared MIPS opcode/funct constants and write-back decode helpers for the
// write-back stage and register file of the single-clock core.
//
// Contents:
//   - opcode and funct constants used by the decode and anything else that
//     needs to recognise instructions
//   - insClassE : how an instruction uses the write-back path
//   - classifyOp: maps a primary opcode to its write-back class
// ---------------------------------------------------------------------------
package wb_regfile_pkg;

  // Primary opcodes (Ins[31:26])
  localparam logic [5:0] R_FORMAT = 6'h00;
  localparam logic [5:0] J        = 6'h02;
  localparam logic [5:0] JAL      = 6'h03;
  localparam logic [5:0] BEQ      = 6'h04;
  localparam logic [5:0] BNE      = 6'h05;
  localparam logic [5:0] ADDI     = 6'h08;
  localparam logic [5:0] ADDIU    = 6'h09;
  localparam logic [5:0] SLTI     = 6'h0A;
  localparam logic [5:0] SLTIU    = 6'h0B;
  localparam logic [5:0] ANDI     = 6'h0C;
  localparam logic [5:0] ORI      = 6'h0D;
  localparam logic [5:0] XORI     = 6'h0E;
  localparam logic [5:0] LUI      = 6'h0F;
  localparam logic [5:0] LW       = 6'h23;
  localparam logic [5:0] SW       = 6'h2B;

  // R-format funct codes (Ins[5:0]) that change write-back behaviour
  localparam logic [5:0] JR_F     = 6'h08;
  localparam logic [5:0] JALR_F   = 6'h09;

  // Write-back class of an instruction
  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,  // no register write
    CLS_RTYPE = 2'd1,  // destination rd, refined by funct
    CLS_ITYPE = 2'd2,  // destination rt, data from Result
    CLS_LINK  = 2'd3   // destination is the link register, data NextPC
  } insClassE;

  // Anything not listed (stores, branches, J, unknown opcodes) is treated as
  // non-writing, so an unexpected opcode can never corrupt the register file.
  function automatic insClassE classifyOp(input logic [5:0] op);
    insClassE cls;
    cls = CLS_NONE;
    case (op)
      R_FORMAT:                     cls = CLS_RTYPE;
      JAL:                          cls = CLS_LINK;
      LW, ADDI, ADDIU, SLTI, SLTIU,
      ANDI, ORI, XORI, LUI:         cls = CLS_ITYPE;
      default:                      cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// ---------------------------------------------------------------------------
// wb_regfile_if
// Bus between the core datapath and the write-back / register-file block.
//
// Signals:
//   ins       : current instruction word
//   result    : memory-access stage output (load data or ALU value)
//   nextPc    : PC+4 of the current instruction (link value)
//   ra1, ra2  : read addresses (rs, rt)
//   rdata1/2  : combinational register reads
//   regWe     : decoded write enable (observability)
//   wreg      : decoded destination index
//   wdata     : decoded write data
//   instCount : retired-instruction counter
//
// Modports: master = datapath side, slave = wb_regfile.
// ---------------------------------------------------------------------------
interface wb_regfile_if;

  logic [31:0] ins;
  logic [31:0] result;
  logic [31:0] nextPc;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        regWe;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic [31:0] instCount;

  modport master (
    output ins, result, nextPc, ra1, ra2,
    input  rdata1, rdata2, regWe, wreg, wdata, instCount
  );

  modport slave (
    input  ins, result, nextPc, ra1, ra2,
    output rdata1, rdata2, regWe, wreg, wdata, instCount
  );

endinterface

// File: rtl/wb_regfile_decode.sv
// ---------------------------------------------------------------------------
// wb_decode
// Combinational write-back decode: maps the instruction word, the MA-stage
// result and the link value to write enable, destination and write data.
//
// Ports:
//   ins_i    : instruction word
//   result_i : MA-stage result
//   nextPc_i : PC+4 (link value)
//   regWe_o  : write enable
//   wreg_o   : destination register index
//   wdata_o  : write data
// ---------------------------------------------------------------------------
module wb_decode
  import wb_regfile_pkg::*;
#(
  parameter int DW     = 32,
  parameter int RA_IDX = 31
) (
  input  logic [31:0]   ins_i,
  input  logic [DW-1:0] result_i,
  input  logic [DW-1:0] nextPc_i,
  output logic          regWe_o,
  output logic [4:0]    wreg_o,
  output logic [DW-1:0] wdata_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  insClassE   cls;

  assign op    = ins_i[31:26];
  assign funct = ins_i[5:0];
  assign rt    = ins_i[20:16];
  assign rd    = ins_i[15:11];
  assign cls   = classifyOp(op);

  // rs and shamt play no part in write-back decode.
  logic unusedInsBits;
  assign unusedInsBits = ^{ins_i[25:21], ins_i[10:6]};

  // Outputs default to "no write" so non-writing and unknown instructions
  // present all-zero destination and data.
  // JR keeps the R-format rd/Result decode but never enables the write;
  // JALR writes the link value into rd.
  always_comb begin
    regWe_o = 1'b0;
    wreg_o  = '0;
    wdata_o = '0;
    case (cls)
      CLS_RTYPE: begin
        wreg_o  = rd;
        wdata_o = (funct == JALR_F) ? nextPc_i : result_i;
        regWe_o = (funct != JR_F);
      end
      CLS_ITYPE: begin
        wreg_o  = rt;
        wdata_o = result_i;
        regWe_o = 1'b1;
      end
      CLS_LINK: begin
        wreg_o  = 5'(RA_IDX);
        wdata_o = nextPc_i;
        regWe_o = 1'b1;
      end
      default: begin
        regWe_o = 1'b0;
        wreg_o  = '0;
        wdata_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
// Write-back stage plus general-purpose register file. Commits the decoded
// write on the rising clock edge, exposes two unbypassed combinational read
// ports and counts retired instructions.
//
// Ports:
//   clk_i : system clock, rising edge
//   rst_i : asynchronous active-high reset (clears registers and counter)
//   bus   : wb_regfile_if.slave (instruction, result, link value, read
//           addresses in; read data, decode observability, counter out)
// ---------------------------------------------------------------------------
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int DW     = 32,
  parameter int RA_IDX = 31
) (
  input  logic         clk_i,
  input  logic         rst_i,
  wb_regfile_if.slave  bus
);

  logic [DW-1:0] regQ [NREG];
  logic [31:0]   instCountQ;
  logic [31:0]   instCountD;
  logic          commitEn;

  wb_decode #(
    .DW     (DW),
    .RA_IDX (RA_IDX)
  ) uDecode (
    .ins_i    (bus.ins),
    .result_i (bus.result),
    .nextPc_i (bus.nextPc),
    .regWe_o  (bus.regWe),
    .wreg_o   (bus.wreg),
    .wdata_o  (bus.wdata)
  );

  // $0 is hardwired: the decode may still report a write to it, but the
  // commit is gated here.
  assign commitEn = bus.regWe && (bus.wreg != 5'd0);

  // Register array. The asynchronous reset drops whatever write is pending
  // in the current cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        regQ[i] <= '0;
      end
    end else if (commitEn) begin
      regQ[bus.wreg] <= bus.wdata;
    end
  end

  // Retired-instruction counter: every edge out of reset retires one
  // instruction, writing or not, and wraps naturally at 2^32.
  always_comb begin
    instCountD = instCountQ + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instCountQ <= '0;
    end else begin
      instCountQ <= instCountD;
    end
  end

  // Read ports return the stored value only. A same-cycle write is not
  // forwarded: doing so would close a combinational loop through the ALU
  // and MA stage of the single-cycle datapath.
  always_comb begin
    bus.rdata1 = (bus.ra1 == 5'd0) ? '0 : regQ[bus.ra1];
    bus.rdata2 = (bus.ra2 == 5'd0) ? '0 : regQ[bus.ra2];
  end

  assign bus.instCount = instCountQ;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus general-purpose register file for the single-clock MIPS core.
- Consumes the memory-access stage's Result (load data or ALU value) together with the current instruction word.
- Decodes the destination register and write enable, and commits the write on the rising clock edge.
- Provides two combinational read ports to the decode/execute path and a retired-instruction counter for debug.

Parameters:
- NREG, 32, number of architectural registers (index width fixed at 5 bits).
- DW, 32, data width.
- RA_IDX, 31, link register index written by JAL.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- Ins  in  32  current instruction word.
- Result  in  32  memory-access stage output (load data or ALU value).
- NextPC  in  32  PC+4 of the current instruction, the link value.
- Ra1  in  5  read address, port 1 (rs).
- Ra2  in  5  read address, port 2 (rt).
- Rdata1  out  32  register[Ra1].
- Rdata2  out  32  register[Ra2].
- RegWE  out  1  decoded write enable (combinational, observability).
- Wreg  out  5  decoded destination index (combinational).
- Wdata  out  32  decoded write data (combinational).
- InstCount  out  32  retired-instruction counter.

Behaviour:
- Reset:
  - RST high asynchronously clears all NREG registers and InstCount to 0.
  - Writes and counting are suppressed while RST is high.
  - On release, the first rising edge with RST low performs a normal commit.
  - A reset asserted mid-cycle discards the pending write.
- Decode (combinational, opcodes from shared constants):
  - R-format (op 0): Wreg = Ins[15:11], Wdata = Result. RegWE = 1 except funct JR (6'h08), where RegWE = 0. Funct JALR (6'h09) writes NextPC to rd.
  - LW and the I-type ALU ops (ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI): Wreg = Ins[20:16], Wdata = Result, RegWE = 1.
  - JAL: Wreg = RA_IDX, Wdata = NextPC, RegWE = 1.
  - SW, BEQ, BNE, J and any unlisted opcode: RegWE = 0, Wreg = 0, Wdata = 0.
- Register 0:
  - Writes with Wreg = 0 are dropped.
  - Reads of index 0 always return 0.
  - The RegWE output still reflects the decode; only the commit is gated.
- Write timing: on the rising CLK edge, if RegWE and Wreg != 0, then reg[Wreg] <= Wdata. Write latency is 1 edge.
- Read ports:
  - Purely combinational, return the stored value, and are not bypassed.
  - A read of the register being written in the same cycle returns the old value until the edge.
  - Bypassing is forbidden: it would close the combinational loop through the ALU and MA stage in the single-cycle datapath.
  - Rdata1 and Rdata2 may address the same register simultaneously.
- InstCount:
  - Increments by 1 every rising edge with RST low, wrapping from 32'hFFFFFFFF to 0.
  - Counts every instruction, including non-writing ones.
- No X propagation: an unknown opcode is treated as non-writing.

Decomposition:
- The opcode and funct constants (R_FORMAT, LW, SW, BEQ, BNE, J, JAL, ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, JR_F, JALR_F) belong in the shared common_param.vh.
- One natural sub-module: wb_decode, a combinational block mapping Ins, Result and NextPC to RegWE, Wreg and Wdata.
- The register array and the counter stay in wb_regfile.

Test Plan:
- Reset: assert RST mid-cycle after registers are written -> all reads return 0 immediately; InstCount = 0; no write on the following edge while RST is high.
- ADDI $8 (Ins 32'h21080005) with Result 32'h5 -> RegWE = 1, Wreg = 8; Ra1 = 8 reads 0 before the edge and 32'h5 after it.
- R-type ADD $10 (rd = 10) with Result 32'hDEADBEEF, then SW with Result 32'h1234 -> $10 = DEADBEEF; SW gives RegWE = 0 and $10 is unchanged.
- JAL with NextPC 32'h00400010 and Result 32'hFFFF -> $31 = 32'h00400010; JR $31 gives RegWE = 0.
- Write to $0 with Result 32'hFFFFFFFF -> Rdata1 at Ra1 = 0 reads 0; LW to $0 likewise reads 0.
- InstCount preset near wrap: run 2^32-1 edges via force, or check by release/force -> 32'hFFFFFFFF rolls to 0 on the next edge; Ra1 = Ra2 = 8 both return the same value.
